writebuffer_coalesce: RTL and testbench

Parametrised write buffer between the cache controller's store path and main memory. It generalises the fixed single-entry write buffer to a DEPTH-entry FIFO. A store that hits a queued, not-yet-issued entry is merged into it byte by byte. A combinational lookup port lets the load path forward pending store bytes before memory has been written. The block drains in order to memory over the existing memen/memdone handshake.

---
 rtl/writebuffer_coalesce.sv | 140 ++++++++++++++
 tb/tb_writebuffer_coalesce.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writebuffer_coalesce.sv
// Purpose: DEPTH-entry in-order write buffer with byte-merge coalescing and load-path forwarding.
// Latency: a store accepted at edge t is presented on memen/memadr/memdata from cycle t+1.
// Backpressure: done drops when full unless the store merges into a queued non-head entry.
//
// Ports:
//   clk, reset (async, active-low)
//   adr/data/byteen/en -> done                  : store request and same-cycle accept
//   rdadr -> rdhit/rdbyteen/rddata               : combinational forwarding lookup
//   memadr/memdata/membyteen/memen <- memdone    : head-entry drain handshake
//   empty, count                                 : occupancy
module writebuffer_coalesce #(
  parameter int DEPTH  = 4,
  parameter int ADR_W  = 30,
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADR_W-1:0]  adr,
  input  logic [DATA_W-1:0] data,
  input  logic [BE_W-1:0]   byteen,
  input  logic              en,
  output logic              done,
  input  logic [ADR_W-1:0]  rdadr,
  output logic              rdhit,
  output logic [BE_W-1:0]   rdbyteen,
  output logic [DATA_W-1:0] rddata,
  output logic [ADR_W-1:0]  memadr,
  output logic [DATA_W-1:0] memdata,
  output logic [BE_W-1:0]   membyteen,
  output logic              memen,
  input  logic              memdone,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [ADR_W-1:0]  ent_adr  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [BE_W-1:0]   ent_be   [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;

  logic              match;
  logic [PTR_W-1:0]  match_idx;
  logic              alloc;
  logic              pop;
  logic [PTR_W-1:0]  ord_idx [DEPTH];

  // ord_idx[k] is the k-th oldest slot; used so younger entries win in the lookup.
  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    assign ord_idx[k] = head + PTR_W'(k);
  end

  // The head is already in flight to memory, so it is never a merge target.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (PTR_W'(i) != head) && (ent_adr[i] == adr)) begin
        match     = 1'b1;
        match_idx = PTR_W'(i);
      end
    end
  end

  // Accept decision uses only the registered count, keeping memdone off the done path.
  assign done  = reset & en & (match | (cnt < CNT_W'(DEPTH)));
  assign alloc = done & ~match;
  assign memen = ent_vld[head];
  assign pop   = memen & memdone;

  assign memadr    = memen ? ent_adr[head]  : '0;
  assign memdata   = memen ? ent_data[head] : '0;
  assign membyteen = memen ? ent_be[head]   : '0;
  assign empty     = (cnt == '0);
  assign count     = cnt;

  // Walk oldest to youngest so later matches overwrite earlier bytes.
  always_comb begin
    rdhit    = 1'b0;
    rdbyteen = '0;
    rddata   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_vld[ord_idx[k]] && (ent_adr[ord_idx[k]] == rdadr)) begin
        rdhit    = 1'b1;
        rdbyteen = rdbyteen | ent_be[ord_idx[k]];
        for (int b = 0; b < BE_W; b++) begin
          if (ent_be[ord_idx[k]][b]) begin
            rddata[8*b +: 8] = ent_data[ord_idx[k]][8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_vld <= '0;
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
    end else begin
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      // alloc only happens with cnt < DEPTH, so tail never equals a popping head here.
      if (alloc) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      if (alloc && !pop) begin
        cnt <= cnt + CNT_W'(1);
      end else if (pop && !alloc) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Payload storage needs no reset: every read of it is qualified by ent_vld.
  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_adr[tail]  <= adr;
      ent_data[tail] <= data;
      ent_be[tail]   <= byteen;
    end else if (done) begin
      ent_be[match_idx] <= ent_be[match_idx] | byteen;
      for (int b = 0; b < BE_W; b++) begin
        if (byteen[b]) begin
          ent_data[match_idx][8*b +: 8] <= data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_writebuffer_coalesce.sv
// Purpose: self-checking bench for writebuffer_coalesce (directed table, corner sequences, random vs queue model).
// Latency: model predicts outputs each cycle before the edge, then advances at the edge.
// Backpressure: model refuses stores when four entries are queued and none can merge.
module tb_writebuffer_coalesce;
  localparam int DEPTH  = 4;
  localparam int ADR_W  = 30;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] data;
  logic [BE_W-1:0]   byteen;
  logic              en;
  logic              done;
  logic [ADR_W-1:0]  rdadr;
  logic              rdhit;
  logic [BE_W-1:0]   rdbyteen;
  logic [DATA_W-1:0] rddata;
  logic [ADR_W-1:0]  memadr;
  logic [DATA_W-1:0] memdata;
  logic [BE_W-1:0]   membyteen;
  logic              memen;
  logic              memdone;
  logic              empty;
  logic [CNT_W-1:0]  count;

  always #5 clk = ~clk;

  writebuffer_coalesce #(.DEPTH(DEPTH), .ADR_W(ADR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .adr(adr), .data(data), .byteen(byteen), .en(en), .done(done),
    .rdadr(rdadr), .rdhit(rdhit), .rdbyteen(rdbyteen), .rddata(rddata),
    .memadr(memadr), .memdata(memdata), .membyteen(membyteen), .memen(memen),
    .memdone(memdone), .empty(empty), .count(count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending stores as a queue, oldest at index 0.
  typedef struct {
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } ent_t;
  ent_t q[$];

  function automatic int find_merge(input logic [ADR_W-1:0] a);
    for (int k = 1; k < q.size(); k++) if (q[k].adr == a) return k;
    return -1;
  endfunction

  function automatic logic model_done();
    return en && ((find_merge(adr) >= 0) || (q.size() < DEPTH));
  endfunction

  task automatic check_model();
    logic              hit;
    logic [BE_W-1:0]   rbe;
    logic [DATA_W-1:0] rd;
    hit = 1'b0; rbe = '0; rd = '0;
    foreach (q[k]) begin
      if (q[k].adr == rdadr) begin
        hit = 1'b1;
        rbe = rbe | q[k].be;
        for (int b = 0; b < BE_W; b++) if (q[k].be[b]) rd[8*b +: 8] = q[k].data[8*b +: 8];
      end
    end
    chk("m_done", done, model_done());
    chk("m_memen", memen, q.size() > 0);
    chk("m_memadr", memadr, (q.size() > 0) ? q[0].adr : '0);
    chk("m_memdata", memdata, (q.size() > 0) ? q[0].data : '0);
    chk("m_membyteen", membyteen, (q.size() > 0) ? q[0].be : '0);
    chk("m_empty", empty, q.size() == 0);
    chk("m_count", count, q.size());
    chk("m_rdhit", rdhit, hit);
    chk("m_rdbyteen", rdbyteen, rbe);
    chk("m_rddata", rddata, rd);
  endtask

  // Called at the edge with the inputs that were presented during the cycle.
  task automatic model_step();
    int   j;
    logic acc;
    logic do_pop;
    ent_t e;
    acc    = model_done();
    j      = find_merge(adr);
    do_pop = (q.size() > 0) && memdone;
    if (acc) begin
      if (j >= 0) begin
        for (int b = 0; b < BE_W; b++) if (byteen[b]) q[j].data[8*b +: 8] = data[8*b +: 8];
        q[j].be = q[j].be | byteen;
      end else begin
        e.adr = adr; e.data = data; e.be = byteen;
        q.push_back(e);
      end
    end
    if (do_pop) void'(q.pop_front());
  endtask

  task automatic drive(input logic e, input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [BE_W-1:0] b, input logic md, input logic [ADR_W-1:0] ra);
    en = e; adr = a; data = d; byteen = b; memdone = md; rdadr = ra;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    q.delete();
    #1;
    reset = 1'b1;
    #1;
  endtask

  typedef struct {
    bit                rst;
    bit                en;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
    bit                md;
    logic [ADR_W-1:0]  ra;
    bit                x_done;
    bit                x_memen;
    logic [DATA_W-1:0] x_memdata;
    int                x_count;
    bit                x_rdhit;
    logic [BE_W-1:0]   x_rdbe;
    logic [DATA_W-1:0] x_rddata;
  } vec_t;
  vec_t tv[$];

  task automatic add(input bit rst, input bit e, input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic [BE_W-1:0] b, input bit md, input logic [ADR_W-1:0] ra,
                     input bit xd, input bit xme, input logic [DATA_W-1:0] xmd, input int xc,
                     input bit xh, input logic [BE_W-1:0] xbe, input logic [DATA_W-1:0] xrd);
    vec_t v;
    v.rst = rst; v.en = e; v.adr = a; v.data = d; v.be = b; v.md = md; v.ra = ra;
    v.x_done = xd; v.x_memen = xme; v.x_memdata = xmd; v.x_count = xc;
    v.x_rdhit = xh; v.x_rdbe = xbe; v.x_rddata = xrd;
    tv.push_back(v);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, '0, '0, '0, 0, '0);
    #1;
    chk("rst_done", done, 0);
    chk("rst_memen", memen, 0);
    chk("rst_memdata", memdata, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_rdhit", rdhit, 0);
    en = 1'b1;
    #1;
    chk("rst_done_en", done, 0);
    en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // rst en adr data be md rdadr | done memen memdata count rdhit rdbe rddata
    // single store then drain
    add(1, 1, 'h0, 'hDEADBEEF, 'hF, 0, 'h0,  1, 0, 'h0,        0, 0, 'h0, 'h0);
    add(0, 0, 'h0, 'h0,        'h0, 0, 'h0,  0, 1, 'hDEADBEEF, 1, 1, 'hF, 'hDEADBEEF);
    add(0, 0, 'h0, 'h0,        'h0, 1, 'h0,  0, 1, 'hDEADBEEF, 1, 1, 'hF, 'hDEADBEEF);
    add(0, 0, 'h0, 'h0,        'h0, 0, 'h0,  0, 0, 'h0,        0, 0, 'h0, 'h0);
    // fill, full refusal, back-to-back drain
    add(0, 1, 'h1, 'hAAAAAAAA, 'hF, 0, 'h5,  1, 0, 'h0,        0, 0, 'h0, 'h0);
    add(0, 1, 'h2, 'hBBBBBBBB, 'hF, 0, 'h5,  1, 1, 'hAAAAAAAA, 1, 0, 'h0, 'h0);
    add(0, 1, 'h3, 'hCCCCCCCC, 'hF, 0, 'h5,  1, 1, 'hAAAAAAAA, 2, 0, 'h0, 'h0);
    add(0, 1, 'h4, 'hDDDDDDDD, 'hF, 0, 'h5,  1, 1, 'hAAAAAAAA, 3, 0, 'h0, 'h0);
    add(0, 1, 'h5, 'hEEEEEEEE, 'hF, 0, 'h5,  0, 1, 'hAAAAAAAA, 4, 0, 'h0, 'h0);
    add(0, 1, 'h5, 'hEEEEEEEE, 'hF, 1, 'h5,  0, 1, 'hAAAAAAAA, 4, 0, 'h0, 'h0);
    add(0, 1, 'h5, 'hEEEEEEEE, 'hF, 1, 'h5,  1, 1, 'hBBBBBBBB, 3, 0, 'h0, 'h0);
    add(0, 0, 'h0, 'h0,        'h0, 1, 'h5,  0, 1, 'hCCCCCCCC, 3, 1, 'hF, 'hEEEEEEEE);
    add(0, 0, 'h0, 'h0,        'h0, 1, 'h5,  0, 1, 'hDDDDDDDD, 2, 1, 'hF, 'hEEEEEEEE);
    add(0, 0, 'h0, 'h0,        'h0, 1, 'h5,  0, 1, 'hEEEEEEEE, 1, 1, 'hF, 'hEEEEEEEE);
    add(0, 0, 'h0, 'h0,        'h0, 0, 'h5,  0, 0, 'h0,        0, 0, 'h0, 'h0);
    // coalesce into non-head entry
    add(0, 1, 'h10, 'h11111111, 'hF, 0, 'h20, 1, 0, 'h0,        0, 0, 'h0, 'h0);
    add(0, 1, 'h20, 'h22222222, 'h3, 0, 'h20, 1, 1, 'h11111111, 1, 0, 'h0, 'h0);
    add(0, 1, 'h20, 'hAABBCCDD, 'h8, 0, 'h20, 1, 1, 'h11111111, 2, 1, 'h3, 'h00002222);
    add(0, 0, 'h0,  'h0,        'h0, 0, 'h20, 0, 1, 'h11111111, 2, 1, 'hB, 'hAA002222);
    // head is never merged into
    add(1, 1, 'h30, 'h30303030, 'hF, 0, 'h30, 1, 0, 'h0,        0, 0, 'h0, 'h0);
    add(0, 1, 'h30, 'h5A5A5A5A, 'hF, 0, 'h30, 1, 1, 'h30303030, 1, 1, 'hF, 'h30303030);
    add(0, 0, 'h0,  'h0,        'h0, 0, 'h30, 0, 1, 'h30303030, 2, 1, 'hF, 'h5A5A5A5A);
    // forwarding priority, then merge behind head during a pop
    add(1, 1, 'h40, 'h12345678, 'hF, 0, 'h40, 1, 0, 'h0,        0, 0, 'h0, 'h0);
    add(0, 1, 'h40, 'h9A000000, 'h8, 0, 'h40, 1, 1, 'h12345678, 1, 1, 'hF, 'h12345678);
    add(0, 1, 'h40, 'h00BC0000, 'h4, 1, 'h40, 1, 1, 'h12345678, 2, 1, 'hF, 'h9A345678);
    add(0, 0, 'h0,  'h0,        'h0, 0, 'h40, 0, 1, 'h9ABC0000, 1, 1, 'hC, 'h9ABC0000);

    foreach (tv[i]) begin
      if (tv[i].rst) pulse_reset();
      drive(tv[i].en, tv[i].adr, tv[i].data, tv[i].be, tv[i].md, tv[i].ra);
      #1;
      chk($sformatf("v%0d_done", i), done, tv[i].x_done);
      chk($sformatf("v%0d_memen", i), memen, tv[i].x_memen);
      chk($sformatf("v%0d_memdata", i), memdata, tv[i].x_memdata);
      chk($sformatf("v%0d_count", i), count, tv[i].x_count);
      chk($sformatf("v%0d_empty", i), empty, tv[i].x_count == 0);
      chk($sformatf("v%0d_rdhit", i), rdhit, tv[i].x_rdhit);
      chk($sformatf("v%0d_rdbyteen", i), rdbyteen, tv[i].x_rdbe);
      chk($sformatf("v%0d_rddata", i), rddata, tv[i].x_rddata);
      check_model();
      advance();
    end

    // Async reset while three writes are pending and the head is in flight.
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, ADR_W'('h50 + i), DATA_W'(32'h50505050 + i), 'hF, 0, 'h50);
      #1;
      check_model();
      advance();
    end
    drive(1, 'h53, 'h53535353, 'hF, 0, 'h50);
    #1;
    chk("ar_pre_count", count, 3);
    chk("ar_pre_memen", memen, 1);
    reset = 1'b0;
    q.delete();
    #1;
    chk("ar_memen", memen, 0);
    chk("ar_empty", empty, 1);
    chk("ar_count", count, 0);
    chk("ar_done", done, 0);
    chk("ar_rdhit", rdhit, 0);
    chk("ar_memdata", memdata, 0);
    #1;
    reset = 1'b1;
    en = 1'b0;
    @(posedge clk); #1;
    drive(1, 'h60, 'h0F0F0F0F, 'h3, 0, 'h50);
    #1;
    check_model();
    advance();
    drive(0, '0, '0, '0, 0, 'h50);
    #1;
    chk("ar_new_memadr", memadr, 'h60);
    chk("ar_new_memdata", memdata, 'h0F0F0F0F);
    chk("ar_new_membyteen", membyteen, 'h3);
    chk("ar_new_count", count, 1);
    chk("ar_old_rdhit", rdhit, 0);
    check_model();
    advance();

    // Randomised traffic over a small address set to force merges and forwarding hits.
    pulse_reset();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 9) < 7), ADR_W'($urandom_range(0, 5)), DATA_W'($urandom()),
            BE_W'($urandom_range(0, 15)), ($urandom_range(0, 9) < 4), ADR_W'($urandom_range(0, 5)));
      #1;
      check_model();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
